// File: rtl/fetch_queue_stage_pkg.sv
// Shared CPU constants: opcodes, func codes, instruction classes and the
// fetch-stage FSM state encoding, plus the head-instruction classifier.
package fetch_queue_stage_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FUNC_SLL  = 6'h00;
    localparam logic [5:0] FUNC_SRL  = 6'h02;
    localparam logic [5:0] FUNC_SRA  = 6'h03;
    localparam logic [5:0] FUNC_SLLV = 6'h04;
    localparam logic [5:0] FUNC_SRLV = 6'h06;
    localparam logic [5:0] FUNC_SRAV = 6'h07;
    localparam logic [5:0] FUNC_ADD  = 6'h20;
    localparam logic [5:0] FUNC_SUB  = 6'h22;
    localparam logic [5:0] FUNC_AND  = 6'h24;
    localparam logic [5:0] FUNC_OR   = 6'h25;
    localparam logic [5:0] FUNC_NOR  = 6'h27;
    localparam logic [5:0] FUNC_SLT  = 6'h2A;

    localparam logic [3:0] INST_TYPE_NONE = 4'd0;
    localparam logic [3:0] INST_TYPE_ADD  = 4'd1;
    localparam logic [3:0] INST_TYPE_SUB  = 4'd2;
    localparam logic [3:0] INST_TYPE_AND  = 4'd3;
    localparam logic [3:0] INST_TYPE_OR   = 4'd4;
    localparam logic [3:0] INST_TYPE_NOR  = 4'd5;
    localparam logic [3:0] INST_TYPE_SLT  = 4'd6;
    localparam logic [3:0] INST_TYPE_SLL  = 4'd7;
    localparam logic [3:0] INST_TYPE_SRL  = 4'd8;
    localparam logic [3:0] INST_TYPE_SRA  = 4'd9;
    localparam logic [3:0] INST_TYPE_LW   = 4'd10;
    localparam logic [3:0] INST_TYPE_SW   = 4'd11;
    localparam logic [3:0] INST_TYPE_BEQ  = 4'd12;
    localparam logic [3:0] INST_TYPE_BNE  = 4'd13;
    localparam logic [3:0] INST_TYPE_JMP  = 4'd14;

    localparam logic [1:0] ST_RESET = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    function automatic logic [3:0] classify_inst(input logic [5:0] op, input logic [5:0] fn);
        logic [3:0] t;
        t = INST_TYPE_NONE;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FUNC_ADD:             t = INST_TYPE_ADD;
                    FUNC_SUB:             t = INST_TYPE_SUB;
                    FUNC_AND:             t = INST_TYPE_AND;
                    FUNC_OR:              t = INST_TYPE_OR;
                    FUNC_NOR:             t = INST_TYPE_NOR;
                    FUNC_SLT:             t = INST_TYPE_SLT;
                    FUNC_SLL, FUNC_SLLV:  t = INST_TYPE_SLL;
                    FUNC_SRL, FUNC_SRLV:  t = INST_TYPE_SRL;
                    FUNC_SRA, FUNC_SRAV:  t = INST_TYPE_SRA;
                    default:              t = INST_TYPE_NONE;
                endcase
            end
            OP_ADDI: t = INST_TYPE_ADD;
            OP_ANDI: t = INST_TYPE_AND;
            OP_ORI:  t = INST_TYPE_OR;
            OP_LW:   t = INST_TYPE_LW;
            OP_SW:   t = INST_TYPE_SW;
            OP_BEQ:  t = INST_TYPE_BEQ;
            OP_BNE:  t = INST_TYPE_BNE;
            OP_J:    t = INST_TYPE_JMP;
            default: t = INST_TYPE_NONE;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/fetch_queue_stage_fifo.sv
// Fetch queue storage: circular buffer of {pc, inst} entries with a
// synchronous clear used for branch redirects.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   wr_en,
    input  logic [W-1:0]           wr_data,
    input  logic                   rd_en,
    output logic [W-1:0]           rd_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (count == '0);

endmodule

// File: rtl/fetch_queue_stage.sv
// Instruction fetch stage: PC sequencing, one-deep memory request pipeline,
// fetch queue with fall-through of the arriving response, head classifier.
//
// state    | meaning
// RESET    | first cycle after reset release, no request
// RUN      | issuing requests while queue plus in-flight is below DEPTH
// FULL     | queue plus in-flight at DEPTH, no request
// FLUSH    | cycle after a redirect, first request to the new target
module fetch_queue_stage
    import fetch_queue_stage_pkg::*;
#(
    parameter int          ADDR_W   = 8,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ctrl_branch,
    input  logic [31:0]            branch_pc,
    output logic                   imem_en,
    output logic [ADDR_W-1:0]      imem_addr,
    input  logic [31:0]            imem_data,
    input  logic                   id_ready,
    output logic                   id_valid,
    output logic [31:0]            if_pc,
    output logic [31:0]            if_pc4,
    output logic [31:0]            if_inst,
    output logic [3:0]             if_ins_type,
    output logic [3:0]             if_ins_number,
    output logic [$clog2(DEPTH):0] q_count
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [31:0]   fpc;
    logic [31:0]   infl_pc;
    logic          inflight;
    logic [CW-1:0] q_cnt;
    logic          fifo_empty;
    logic [63:0]   fifo_head;
    logic          wr_en;
    logic          rd_en;
    logic          head_valid;
    logic [31:0]   head_pc;
    logic [31:0]   head_inst;
    logic [CW:0]   occ_now;
    logic [CW:0]   occ_next;

    assign occ_now  = {1'b0, q_cnt} + (CW+1)'(inflight);
    assign imem_en  = !rst && !ctrl_branch && (state != ST_RESET) && (occ_now < (CW+1)'(DEPTH));
    assign imem_addr = fpc[ADDR_W-1:0];

    // An arriving response is presented directly when the queue is empty,
    // so a redirect reaches decode two cycles later.
    assign head_valid = !rst && (!fifo_empty || inflight);
    assign {head_pc, head_inst} = fifo_empty ? {infl_pc, imem_data} : fifo_head;
    assign rd_en = head_valid && id_ready && !fifo_empty;
    assign wr_en = !rst && !ctrl_branch && inflight && !(fifo_empty && id_ready);

    assign occ_next = {1'b0, q_cnt} + (CW+1)'(wr_en) + (CW+1)'(imem_en) - (CW+1)'(rd_en);

    fetch_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr     (ctrl_branch),
        .wr_en   (wr_en),
        .wr_data ({infl_pc, imem_data}),
        .rd_en   (rd_en),
        .rd_data (fifo_head),
        .empty   (fifo_empty),
        .count   (q_cnt)
    );

    always_comb begin
        state_next = state;
        if (ctrl_branch) begin
            state_next = ST_FLUSH;
        end else begin
            case (state)
                ST_RESET: state_next = ST_RUN;
                ST_FLUSH: state_next = ST_RUN;
                default:  state_next = (occ_next >= (CW+1)'(DEPTH)) ? ST_FULL : ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RESET;
            fpc      <= RESET_PC;
            inflight <= 1'b0;
            infl_pc  <= '0;
        end else begin
            state <= state_next;
            if (ctrl_branch) begin
                fpc      <= branch_pc;
                inflight <= 1'b0;
            end else begin
                inflight <= imem_en;
                if (imem_en) begin
                    fpc     <= fpc + 32'd1;
                    infl_pc <= fpc;
                end
            end
        end
    end

    assign id_valid      = head_valid;
    assign if_pc         = head_valid ? head_pc : '0;
    assign if_pc4        = head_valid ? head_pc + 32'd1 : '0;
    assign if_inst       = head_valid ? head_inst : '0;
    assign if_ins_type   = head_valid ? classify_inst(head_inst[31:26], head_inst[5:0]) : INST_TYPE_NONE;
    assign if_ins_number = head_valid ? head_pc[3:0] : '0;
    assign q_count       = rst ? '0 : q_cnt;

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage: startup, stall/resume, redirects,
// classification, PC wrap and mid-run reset against a word n = n memory.
module tb_fetch_queue_stage;
    import fetch_queue_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ctrl_branch;
    logic [31:0] branch_pc;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data = 32'd0;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic [31:0] if_inst;
    logic [3:0]  if_ins_type;
    logic [3:0]  if_ins_number;
    logic [2:0]  q_count;

    logic [31:0] mem [256];
    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_pc;

    always #5 clk = ~clk;

    fetch_queue_stage #(.ADDR_W(8), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .ctrl_branch   (ctrl_branch),
        .branch_pc     (branch_pc),
        .imem_en       (imem_en),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .id_ready      (id_ready),
        .id_valid      (id_valid),
        .if_pc         (if_pc),
        .if_pc4        (if_pc4),
        .if_inst       (if_inst),
        .if_ins_type   (if_ins_type),
        .if_ins_number (if_ins_number),
        .q_count       (q_count)
    );

    always @(posedge clk) begin
        if (imem_en) imem_data <= mem[imem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = i;
        mem[8'h80] = 32'h2022_0005;
        mem[8'h81] = 32'h0043_1007;
        mem[8'h82] = 32'hFC00_0000;

        rst = 1'b1; ctrl_branch = 1'b0; branch_pc = 32'd0; id_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_imem_en",  32'(imem_en), 32'd0);
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_q_count",  32'(q_count), 32'd0);
        chk("rst_if_inst",  if_inst, 32'd0);
        chk("rst_if_pc",    if_pc, 32'd0);
        chk("rst_type",     32'(if_ins_type), 32'(INST_TYPE_NONE));

        next_cycle(); rst = 1'b0;
        @(negedge clk);
        chk("c0_imem_en", 32'(imem_en), 32'd0);
        next_cycle(); @(negedge clk);
        chk("c1_imem_en",   32'(imem_en), 32'd1);
        chk("c1_imem_addr", 32'(imem_addr), 32'd0);
        chk("c1_id_valid",  32'(id_valid), 32'd0);

        exp_pc = 32'd0;
        for (int i = 0; i < 8; i++) begin
            next_cycle(); @(negedge clk);
            chk("run_valid", 32'(id_valid), 32'd1);
            chk("run_pc",    if_pc, exp_pc);
            chk("run_pc4",   if_pc4, exp_pc + 32'd1);
            chk("run_inst",  if_inst, exp_pc);
            exp_pc++;
        end

        // Build 3 queued + 1 in flight, then redirect to 0x40
        next_cycle(); id_ready = 1'b0;
        @(negedge clk);
        chk("stall_head", if_pc, 32'd8);
        for (int j = 1; j <= 2; j++) begin
            next_cycle(); @(negedge clk);
            chk("stall_qcnt", 32'(q_count), 32'(j));
        end
        next_cycle(); ctrl_branch = 1'b1; branch_pc = 32'h40;
        @(negedge clk);
        chk("br_qcnt3",   32'(q_count), 32'd3);
        chk("br_no_req",  32'(imem_en), 32'd0);
        next_cycle(); ctrl_branch = 1'b0; id_ready = 1'b1;
        @(negedge clk);
        chk("br_flush_qcnt",  32'(q_count), 32'd0);
        chk("br_flush_valid", 32'(id_valid), 32'd0);
        chk("br_req_en",      32'(imem_en), 32'd1);
        chk("br_req_addr",    32'(imem_addr), 32'h40);
        next_cycle(); @(negedge clk);
        chk("br_tgt_valid", 32'(id_valid), 32'd1);
        chk("br_tgt_pc",    if_pc, 32'h40);
        chk("br_tgt_num",   32'(if_ins_number), 32'd0);
        chk("br_tgt_inst",  if_inst, 32'h40);
        exp_pc = 32'h41;
        for (int i = 0; i < 3; i++) begin
            next_cycle(); @(negedge clk);
            chk("post_br_pc", if_pc, exp_pc);
            exp_pc++;
        end

        // Saturate the queue, then drain without loss or duplication
        next_cycle(); id_ready = 1'b0;
        for (int j = 0; j < 6; j++) begin
            if (j > 0) next_cycle();
            @(negedge clk);
            if (j >= 4) begin
                chk("full_qcnt",  32'(q_count), 32'd4);
                chk("full_no_en", 32'(imem_en), 32'd0);
                chk("full_head",  if_pc, 32'h44);
            end
        end
        next_cycle(); id_ready = 1'b1;
        @(negedge clk);
        chk("resume_qcnt", 32'(q_count), 32'd4);
        chk("resume_pc",   if_pc, exp_pc);
        exp_pc++;
        for (int i = 0; i < 7; i++) begin
            next_cycle(); @(negedge clk);
            chk("resume_valid", 32'(id_valid), 32'd1);
            chk("resume_pc",    if_pc, exp_pc);
            exp_pc++;
        end

        // Redirect with a handshake in the same cycle
        next_cycle(); ctrl_branch = 1'b1; branch_pc = 32'h80;
        @(negedge clk);
        chk("brhs_head",  if_pc, exp_pc);
        chk("brhs_valid", 32'(id_valid), 32'd1);
        chk("brhs_qcnt",  32'(q_count), 32'd2);
        next_cycle(); ctrl_branch = 1'b0;
        @(negedge clk);
        chk("brhs_qcnt0",  32'(q_count), 32'd0);
        chk("empty_valid", 32'(id_valid), 32'd0);
        chk("empty_inst",  if_inst, 32'd0);
        chk("empty_type",  32'(if_ins_type), 32'(INST_TYPE_NONE));
        next_cycle(); @(negedge clk);
        chk("addi_pc",   if_pc, 32'h80);
        chk("addi_inst", if_inst, 32'h2022_0005);
        chk("addi_type", 32'(if_ins_type), 32'(INST_TYPE_ADD));
        next_cycle(); @(negedge clk);
        chk("srav_pc",   if_pc, 32'h81);
        chk("srav_type", 32'(if_ins_type), 32'(INST_TYPE_SRA));
        next_cycle(); @(negedge clk);
        chk("op3f_pc",   if_pc, 32'h82);
        chk("op3f_type", 32'(if_ins_type), 32'(INST_TYPE_NONE));
        chk("op3f_num",  32'(if_ins_number), 32'd2);

        // PC wrap at 0xFFFF_FFFF
        next_cycle(); ctrl_branch = 1'b1; branch_pc = 32'hFFFF_FFFF;
        next_cycle(); ctrl_branch = 1'b0;
        @(negedge clk);
        chk("wrap_en",   32'(imem_en), 32'd1);
        chk("wrap_addr", 32'(imem_addr), 32'hFF);
        next_cycle(); @(negedge clk);
        chk("wrap_addr_next", 32'(imem_addr), 32'h00);
        chk("wrap_pc",        if_pc, 32'hFFFF_FFFF);
        chk("wrap_pc4",       if_pc4, 32'h0);
        chk("wrap_inst",      if_inst, 32'hFF);
        chk("wrap_num",       32'(if_ins_number), 32'hF);
        next_cycle(); @(negedge clk);
        chk("wrap_pc_after", if_pc, 32'h0);
        chk("wrap_valid",    32'(id_valid), 32'd1);

        // Mid-run reset with entries queued
        next_cycle(); id_ready = 1'b0;
        next_cycle();
        next_cycle(); rst = 1'b1;
        @(negedge clk);
        chk("mrst_en",    32'(imem_en), 32'd0);
        chk("mrst_valid", 32'(id_valid), 32'd0);
        chk("mrst_qcnt",  32'(q_count), 32'd0);
        chk("mrst_pc",    if_pc, 32'd0);
        next_cycle(); rst = 1'b0; id_ready = 1'b1;
        @(negedge clk);
        chk("mrst_c0_en",    32'(imem_en), 32'd0);
        chk("mrst_c0_qcnt",  32'(q_count), 32'd0);
        chk("mrst_c0_valid", 32'(id_valid), 32'd0);
        next_cycle(); @(negedge clk);
        chk("mrst_c1_en",   32'(imem_en), 32'd1);
        chk("mrst_c1_addr", 32'(imem_addr), 32'd0);
        next_cycle(); @(negedge clk);
        chk("mrst_c2_pc",    if_pc, 32'd0);
        chk("mrst_c2_valid", 32'(id_valid), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
